// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller:
// states, opcodes, ALU codes, mux selects, decode classes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_MEMWB  = 3'd4
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_MEM   = 4'b0100;

    // R-type extension codes, reused as immediate-form opcodes
    localparam logic [3:0] FN_AND = 4'b0001;
    localparam logic [3:0] FN_OR  = 4'b0010;
    localparam logic [3:0] FN_XOR = 4'b0011;
    localparam logic [3:0] FN_ADD = 4'b0101;
    localparam logic [3:0] FN_SUB = 4'b1001;
    localparam logic [3:0] FN_CMP = 4'b1011;
    localparam logic [3:0] FN_MOV = 4'b1101;

    localparam logic [3:0] EXT_LSH  = 4'b0100;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_CMP = 4'b0101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_MOV = 2'b10;

    localparam logic [1:0] A_SRC = 2'b00;
    localparam logic [1:0] A_IMM = 2'b01;
    localparam logic [1:0] A_ONE = 2'b10;

    localparam logic [1:0] ADDR_SRC = 2'b00;

    typedef enum logic [3:0] {
        CL_ILL,
        CL_ALU,
        CL_ALUI,
        CL_CMP,
        CL_CMPI,
        CL_MOV,
        CL_MOVI,
        CL_LSH,
        CL_LSHI,
        CL_LOAD,
        CL_STOR
    } cls_e;

    typedef struct packed {
        cls_e       cls;
        logic [3:0] alu;
        logic       sign;
    } dec_t;

    function automatic logic is_fn(input logic [3:0] fn);
        return fn inside {FN_AND, FN_OR, FN_XOR, FN_ADD,
                          FN_SUB, FN_CMP, FN_MOV};
    endfunction

    function automatic logic [3:0] fn_alu(input logic [3:0] fn);
        logic [3:0] r;
        case (fn)
            FN_AND:  r = ALU_AND;
            FN_OR:   r = ALU_OR;
            FN_XOR:  r = ALU_XOR;
            FN_SUB:  r = ALU_SUB;
            FN_CMP:  r = ALU_CMP;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/controller_fsm_if.sv
// Control interface between controller_fsm (master)
// and the datapath (slave), plus the memory handshake.
interface controller_fsm_if #(
    parameter int STATE_W = 3
);
    logic [15:0]        instruction;
    logic               memReady;
    logic [3:0]         aluControl;
    logic [1:0]         exMemResultEn;
    logic [1:0]         mux4En;
    logic [1:0]         regpcCont;
    logic               pcRegEn;
    logic               srcRegEn;
    logic               dstRegEn;
    logic               immRegEn;
    logic               resultRegEn;
    logic               signEn;
    logic               regFileEn;
    logic               pcRegMuxEn;
    logic               shiftALUMuxEn;
    logic               regImmMuxEn;
    logic               irS;
    logic               memRead;
    logic               memWrite;
    logic               flagEn;
    logic               illegalOp;
    logic               busErr;
    logic [STATE_W-1:0] state;

    modport master (
        input  instruction, memReady,
        output aluControl, exMemResultEn, mux4En, regpcCont,
        output pcRegEn, srcRegEn, dstRegEn, immRegEn,
        output resultRegEn, signEn, regFileEn, pcRegMuxEn,
        output shiftALUMuxEn, regImmMuxEn, irS,
        output memRead, memWrite, flagEn,
        output illegalOp, busErr, state
    );

    modport slave (
        output instruction, memReady,
        input  aluControl, exMemResultEn, mux4En, regpcCont,
        input  pcRegEn, srcRegEn, dstRegEn, immRegEn,
        input  resultRegEn, signEn, regFileEn, pcRegMuxEn,
        input  shiftALUMuxEn, regImmMuxEn, irS,
        input  memRead, memWrite, flagEn,
        input  illegalOp, busErr, state
    );
endinterface

// File: rtl/instr_decode.sv
// Combinational instruction classifier: class, ALU code
// and immediate sign-extension select.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [3:0] ext_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o.cls  = CL_ILL;
        dec_o.alu  = ALU_ADD;
        dec_o.sign = 1'b0;
        unique case (1'b1)
            (op_i == OP_RTYPE) && is_fn(ext_i): begin
                dec_o.alu = fn_alu(ext_i);
                if (ext_i == FN_CMP)
                    dec_o.cls = CL_CMP;
                else if (ext_i == FN_MOV)
                    dec_o.cls = CL_MOV;
                else
                    dec_o.cls = CL_ALU;
            end
            is_fn(op_i): begin
                dec_o.alu  = fn_alu(op_i);
                dec_o.sign = op_i inside {FN_ADD, FN_SUB,
                                          FN_CMP, FN_MOV};
                if (op_i == FN_CMP)
                    dec_o.cls = CL_CMPI;
                else if (op_i == FN_MOV)
                    dec_o.cls = CL_MOVI;
                else
                    dec_o.cls = CL_ALUI;
            end
            (op_i == OP_SHIFT) && (ext_i == EXT_LSH):
                dec_o.cls = CL_LSH;
            (op_i == OP_SHIFT) && (ext_i[3:1] == 3'b000):
                dec_o.cls = CL_LSHI;
            (op_i == OP_MEM) && (ext_i == EXT_LOAD):
                dec_o.cls = CL_LOAD;
            (op_i == OP_MEM) && (ext_i == EXT_STOR):
                dec_o.cls = CL_STOR;
            default: ;
        endcase
    end

endmodule

// File: rtl/controller_fsm.sv
// Multicycle control FSM for the 16-bit datapath with
// memory handshake timeout.
module controller_fsm
    import ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int STATE_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    controller_fsm_if.master  bus
);

    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    cls_e       cls_q, cls_d;
    logic [3:0] alu_q, alu_d;
    logic       sign_q, sign_d;
    dec_t       dec;
    logic       waiting;
    logic       timeout;
    logic [7:0] unused_fields;

    assign unused_fields = {bus.instruction[11:8],
                            bus.instruction[3:0]};

    instr_decode u_dec (
        .op_i  (bus.instruction[15:12]),
        .ext_i (bus.instruction[7:4]),
        .dec_o (dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cls_q   <= CL_ILL;
            alu_q   <= ALU_ADD;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cls_q   <= cls_d;
            alu_q   <= alu_d;
            sign_q  <= sign_d;
        end
    end

    assign bus.state = STATE_W'(state_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cls_d   = cls_q;
        alu_d   = alu_q;
        sign_d  = sign_q;
        waiting = 1'b0;
        timeout = 1'b0;

        bus.aluControl    = ALU_ADD;
        bus.exMemResultEn = RES_ALU;
        bus.mux4En        = A_SRC;
        bus.regpcCont     = ADDR_SRC;
        bus.pcRegEn       = 1'b0;
        bus.srcRegEn      = 1'b0;
        bus.dstRegEn      = 1'b0;
        bus.immRegEn      = 1'b0;
        bus.resultRegEn   = 1'b0;
        bus.signEn        = 1'b0;
        bus.regFileEn     = 1'b0;
        bus.pcRegMuxEn    = 1'b0;
        bus.shiftALUMuxEn = 1'b0;
        bus.regImmMuxEn   = 1'b0;
        bus.irS           = 1'b0;
        bus.memRead       = 1'b0;
        bus.memWrite      = 1'b0;
        bus.flagEn        = 1'b0;
        bus.illegalOp     = 1'b0;
        bus.busErr        = 1'b0;

        // outputs stay silent for as long as reset is held
        if (reset) begin
            unique case (state_q)
                S_FETCH: begin
                    bus.memRead = 1'b1;
                    waiting     = !bus.memReady;
                    if (bus.memReady) begin
                        bus.irS     = 1'b1;
                        bus.pcRegEn = 1'b1;
                        state_d     = S_DECODE;
                    end
                end
                S_DECODE: begin
                    bus.srcRegEn  = 1'b1;
                    bus.dstRegEn  = 1'b1;
                    bus.immRegEn  = 1'b1;
                    bus.signEn    = dec.sign;
                    bus.illegalOp = dec.cls == CL_ILL;
                    cls_d         = dec.cls;
                    alu_d         = dec.alu;
                    sign_d        = dec.sign;
                    if (dec.cls == CL_ILL)
                        state_d = S_FETCH;
                    else if (dec.cls inside {CL_LOAD, CL_STOR})
                        state_d = S_MEM;
                    else
                        state_d = S_EXEC;
                end
                S_EXEC: begin
                    bus.aluControl = alu_q;
                    bus.signEn     = sign_q;
                    state_d        = S_FETCH;
                    unique case (cls_q)
                        CL_ALU:
                            bus.regFileEn = 1'b1;
                        CL_ALUI: begin
                            bus.mux4En      = A_IMM;
                            bus.regImmMuxEn = 1'b1;
                            bus.regFileEn   = 1'b1;
                        end
                        CL_CMP:
                            bus.flagEn = 1'b1;
                        CL_CMPI: begin
                            bus.mux4En      = A_IMM;
                            bus.regImmMuxEn = 1'b1;
                            bus.flagEn      = 1'b1;
                        end
                        CL_MOV: begin
                            bus.exMemResultEn = RES_MOV;
                            bus.regFileEn     = 1'b1;
                        end
                        CL_MOVI: begin
                            bus.exMemResultEn = RES_MOV;
                            bus.mux4En        = A_IMM;
                            bus.regImmMuxEn   = 1'b1;
                            bus.regFileEn     = 1'b1;
                        end
                        CL_LSH: begin
                            bus.shiftALUMuxEn = 1'b1;
                            bus.regFileEn     = 1'b1;
                        end
                        CL_LSHI: begin
                            bus.shiftALUMuxEn = 1'b1;
                            bus.regImmMuxEn   = 1'b1;
                            bus.regFileEn     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    bus.memRead  = cls_q == CL_LOAD;
                    bus.memWrite = cls_q == CL_STOR;
                    waiting      = !bus.memReady;
                    if (bus.memReady)
                        state_d = (cls_q == CL_LOAD) ? S_MEMWB
                                                     : S_FETCH;
                end
                S_MEMWB: begin
                    bus.exMemResultEn = RES_MEM;
                    bus.regFileEn     = 1'b1;
                    state_d           = S_FETCH;
                end
                default:
                    state_d = S_FETCH;
            endcase

            // memReady on the last allowed cycle still wins
            timeout = waiting && (cnt_q == LIMIT_M1);
            if (timeout) begin
                bus.busErr = 1'b1;
                state_d    = S_FETCH;
            end

            if (state_d != state_q || timeout)
                cnt_d = '0;
            else if (waiting)
                cnt_d = cnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_controller_fsm.sv
// Directed bench for controller_fsm: decode classes, memory
// waits, timeout, illegal opcode and mid-access reset.
module tb_controller_fsm;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errs   = 0;
    int   checks = 0;
    int   n;
    int   bcnt;
    int   pcnt;
    int   wcnt;
    logic [25:0] outs;

    always #5 clk = ~clk;

    controller_fsm_if #(.STATE_W(3)) bus ();

    controller_fsm #(
        .WAIT_LIMIT (15),
        .STATE_W    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign outs = {bus.aluControl, bus.exMemResultEn,
                   bus.mux4En, bus.regpcCont, bus.pcRegEn,
                   bus.srcRegEn, bus.dstRegEn, bus.immRegEn,
                   bus.resultRegEn, bus.signEn, bus.regFileEn,
                   bus.pcRegMuxEn, bus.shiftALUMuxEn,
                   bus.regImmMuxEn, bus.irS, bus.memRead,
                   bus.memWrite, bus.flagEn, bus.illegalOp,
                   bus.busErr};

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ins,
                         input logic rdy);
        bus.instruction = ins;
        bus.memReady    = rdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset           = 1'b0;
        bus.instruction = 16'h0000;
        bus.memReady    = 1'b1;
        tick();
        check("rst_outs", 32'(outs), 0);
        check("rst_state", 32'(bus.state), 0);
        tick();
        check("rst_outs2", 32'(outs), 0);
        reset = 1'b1;

        // ADD R1,R2
        drive(16'h0152, 1'b1);
        check("add_f_state", 32'(bus.state), 0);
        check("add_f_rd", 32'(bus.memRead), 1);
        check("add_f_irs", 32'(bus.irS), 1);
        check("add_f_pc", 32'(bus.pcRegEn), 1);
        tick();
        check("add_d_state", 32'(bus.state), 1);
        check("add_d_src", 32'(bus.srcRegEn), 1);
        check("add_d_imm", 32'(bus.immRegEn), 1);
        check("add_d_sign", 32'(bus.signEn), 0);
        check("add_d_ill", 32'(bus.illegalOp), 0);
        tick();
        check("add_e_state", 32'(bus.state), 2);
        check("add_e_alu", 32'(bus.aluControl), 0);
        check("add_e_mux4", 32'(bus.mux4En), 0);
        check("add_e_rf", 32'(bus.regFileEn), 1);
        check("add_e_res", 32'(bus.exMemResultEn), 0);
        tick();
        check("add_back_f", 32'(bus.state), 0);

        // ADDI R3,#-1
        drive(16'h53FF, 1'b1);
        tick();
        check("addi_d_sign", 32'(bus.signEn), 1);
        tick();
        check("addi_e_mux4", 32'(bus.mux4En), 1);
        check("addi_e_rim", 32'(bus.regImmMuxEn), 1);
        check("addi_e_rf", 32'(bus.regFileEn), 1);
        tick();

        // ANDI
        drive(16'h13FF, 1'b1);
        tick();
        check("andi_d_sign", 32'(bus.signEn), 0);
        tick();
        check("andi_e_alu", 32'(bus.aluControl), 2);
        check("andi_e_rf", 32'(bus.regFileEn), 1);
        tick();

        // LOAD with three wait cycles in MEM
        n = 0;
        drive(16'h4406, 1'b1);
        tick(); n++;
        check("ld_d_state", 32'(bus.state), 1);
        tick(); n++;
        for (int i = 0; i < 3; i++) begin
            drive(16'h4406, 1'b0);
            check("ld_m_state", 32'(bus.state), 3);
            check("ld_m_rd", 32'(bus.memRead), 1);
            check("ld_m_rf", 32'(bus.regFileEn), 0);
            tick(); n++;
        end
        drive(16'h4406, 1'b1);
        check("ld_m_rd_rdy", 32'(bus.memRead), 1);
        tick(); n++;
        check("ld_wb_state", 32'(bus.state), 4);
        check("ld_wb_res", 32'(bus.exMemResultEn), 1);
        check("ld_wb_rf", 32'(bus.regFileEn), 1);
        check("ld_wb_rd", 32'(bus.memRead), 0);
        tick(); n++;
        check("ld_back_f", 32'(bus.state), 0);
        check("ld_cycles", 32'(n), 7);

        // LOAD with memory always ready
        drive(16'h4406, 1'b1);
        n = 0;
        do begin tick(); n++; end
        while (bus.state != 0 && n < 20);
        check("ld_lat", 32'(n), 4);

        // STOR with two wait cycles
        drive(16'h4446, 1'b1);
        tick();
        check("st_d_rf", 32'(bus.regFileEn), 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(16'h4446, 1'b0);
            check("st_m_state", 32'(bus.state), 3);
            check("st_m_wr", 32'(bus.memWrite), 1);
            check("st_m_rf", 32'(bus.regFileEn), 0);
            tick();
        end
        drive(16'h4446, 1'b1);
        check("st_m_wr_rdy", 32'(bus.memWrite), 1);
        check("st_m_rd", 32'(bus.memRead), 0);
        tick();
        check("st_back_f", 32'(bus.state), 0);
        check("st_f_wr", 32'(bus.memWrite), 0);

        drive(16'h4446, 1'b1);
        n = 0;
        do begin tick(); n++; end
        while (bus.state != 0 && n < 20);
        check("st_lat", 32'(n), 3);

        // CMP
        drive(16'h01B2, 1'b1);
        tick();
        tick();
        check("cmp_e_flag", 32'(bus.flagEn), 1);
        check("cmp_e_rf", 32'(bus.regFileEn), 0);
        check("cmp_e_alu", 32'(bus.aluControl), 5);
        tick();

        // MOVI
        drive(16'hD105, 1'b1);
        tick();
        check("movi_d_sign", 32'(bus.signEn), 1);
        tick();
        check("movi_e_res", 32'(bus.exMemResultEn), 2);
        check("movi_e_mux4", 32'(bus.mux4En), 1);
        check("movi_e_rf", 32'(bus.regFileEn), 1);
        tick();

        // LSHI then LSH
        drive(16'h8213, 1'b1);
        tick();
        tick();
        check("lshi_e_sh", 32'(bus.shiftALUMuxEn), 1);
        check("lshi_e_rim", 32'(bus.regImmMuxEn), 1);
        check("lshi_e_rf", 32'(bus.regFileEn), 1);
        tick();
        drive(16'h8242, 1'b1);
        tick();
        tick();
        check("lsh_e_sh", 32'(bus.shiftALUMuxEn), 1);
        check("lsh_e_rim", 32'(bus.regImmMuxEn), 0);
        check("lsh_e_state", 32'(bus.state), 2);
        tick();

        // fetch timeout after 15 idle cycles
        bcnt = 0;
        pcnt = 0;
        for (int i = 0; i < 15; i++) begin
            drive(16'h0152, 1'b0);
            bcnt += int'(bus.busErr);
            pcnt += int'(bus.pcRegEn | bus.irS);
            if (i == 14)
                check("to_buserr", 32'(bus.busErr), 1);
            tick();
        end
        drive(16'h0152, 1'b0);
        check("to_pulses", 32'(bcnt), 1);
        check("to_no_pc", 32'(pcnt), 0);
        check("to_state", 32'(bus.state), 0);
        check("to_cleared", 32'(bus.busErr), 0);

        // illegal opcode
        drive(16'hF000, 1'b1);
        check("ill_f_irs", 32'(bus.irS), 1);
        tick();
        check("ill_d_state", 32'(bus.state), 1);
        check("ill_d_pulse", 32'(bus.illegalOp), 1);
        check("ill_d_rf", 32'(bus.regFileEn), 0);
        tick();
        check("ill_back_f", 32'(bus.state), 0);
        check("ill_cleared", 32'(bus.illegalOp), 0);

        // ready on the last allowed cycle is a success
        for (int i = 0; i < 14; i++) begin
            drive(16'h0152, 1'b0);
            tick();
        end
        drive(16'h0152, 1'b1);
        check("edge_buserr", 32'(bus.busErr), 0);
        check("edge_pc", 32'(bus.pcRegEn), 1);
        tick();
        check("edge_dec", 32'(bus.state), 1);
        tick();
        tick();

        // reset in the middle of a STOR
        drive(16'h4446, 1'b1);
        tick();
        tick();
        drive(16'h4446, 1'b0);
        check("rm_wr_pre", 32'(bus.memWrite), 1);
        reset = 1'b0;
        #1;
        check("rm_outs", 32'(outs), 0);
        check("rm_state", 32'(bus.state), 0);
        tick();
        check("rm_outs_hold", 32'(outs), 0);
        reset = 1'b1;
        drive(16'h0152, 1'b1);
        check("rm_rel_state", 32'(bus.state), 0);
        check("rm_rel_rd", 32'(bus.memRead), 1);
        wcnt = int'(bus.memWrite);
        for (int i = 0; i < 3; i++) begin
            tick();
            wcnt += int'(bus.memWrite);
        end
        check("rm_no_write", 32'(wcnt), 0);
        check("rm_back_f", 32'(bus.state), 0);

        $display("Result: errors=%0d of %0d checks",
                 errs, checks);
        $finish;
    end

endmodule
